// File: rtl/puf_ctrl_pkg.sv
// Shared definitions for the arbiter PUF challenge sequencer: FSM state encoding,
// default geometry and the response synchronizer depth.
package puf_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int CH_W_DEF       = 8;
  localparam int SETTLE_CYC_DEF = 16;
  localparam int VOTES_DEF      = 7;
  localparam int CNT_W_DEF      = 4;
  localparam int SYNC_DEPTH     = 2;

endpackage

// File: rtl/puf_resp_sync.sv
// Multi-flop synchronizer bringing the raw, clock-asynchronous PUF response into clk.
module puf_resp_sync
  import puf_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] sync_sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_sr <= '0;
    else      sync_sr <= {sync_sr[SYNC_DEPTH-2:0], d};
  end

  assign q = sync_sr[SYNC_DEPTH-1];

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Runs VOTES clear/launch/sample evaluations of an arbiter PUF per accepted challenge
// and returns the majority bit plus an all-agree stability flag.
module puf_challenge_sequencer
  import puf_ctrl_pkg::*;
#(
  parameter int CH_W       = CH_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int VOTES      = VOTES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [CH_W-1:0] req_ch,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_bit,
  output logic            rsp_stable,
  output logic [CH_W-1:0] puf_ch,
  output logic            puf_launch,
  output logic            puf_arb_rst,
  input  logic            puf_resp,
  output logic            busy
);

  localparam logic [7:0]       TMR_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] VOTES_C  = CNT_W'(VOTES);
  localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(VOTES / 2);

  state_t           state, state_nxt;
  logic [7:0]       phase_tmr;
  logic [CNT_W-1:0] vote_cnt, ones_cnt, vote_inc;
  logic             resp_sync, accept, launch_nxt;

  puf_resp_sync u_resp_sync (
    .clk (clk),
    .rst (rst),
    .d   (puf_resp),
    .q   (resp_sync)
  );

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid && req_ready;
  assign vote_inc  = vote_cnt + CNT_W'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_CLEAR;
      S_CLEAR:  if (phase_tmr == 8'd0) state_nxt = S_LAUNCH;
      S_LAUNCH: if (phase_tmr == 8'd0) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (vote_inc == VOTES_C) ? S_DONE : S_CLEAR;
      S_DONE:   if (rsp_valid && rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    // Launch/arbiter-clear are registered from the next state so they track it glitch-free.
    launch_nxt = (state_nxt == S_LAUNCH) || (state_nxt == S_SAMPLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      puf_launch  <= 1'b0;
      puf_arb_rst <= 1'b1;
    end else begin
      state       <= state_nxt;
      puf_launch  <= launch_nxt;
      puf_arb_rst <= ~launch_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_tmr  <= '0;
      vote_cnt   <= '0;
      ones_cnt   <= '0;
      puf_ch     <= '0;
      rsp_valid  <= 1'b0;
      rsp_bit    <= 1'b0;
      rsp_stable <= 1'b0;
    end else begin
      if ((state_nxt != state) && ((state_nxt == S_CLEAR) || (state_nxt == S_LAUNCH)))
        phase_tmr <= TMR_LOAD;
      else if (phase_tmr != 8'd0)
        phase_tmr <= phase_tmr - 8'd1;

      if (accept) begin
        puf_ch   <= req_ch;
        vote_cnt <= '0;
        ones_cnt <= '0;
      end else if (state == S_SAMPLE) begin
        vote_cnt <= vote_inc;
        ones_cnt <= ones_cnt + CNT_W'(resp_sync);
      end

      // First DONE cycle resolves the vote; the result then holds until the handshake.
      if (state == S_DONE) begin
        if (!rsp_valid) begin
          rsp_valid  <= 1'b1;
          rsp_bit    <= (ones_cnt > HALF_C);
          rsp_stable <= (ones_cnt == '0) || (ones_cnt == VOTES_C);
        end else if (rsp_ready) begin
          rsp_valid  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Randomized self-checking bench for puf_challenge_sequencer against a vote-level reference model.
module tb_puf_challenge_sequencer;

  localparam int CH_W   = 8;
  localparam int SETTLE = 16;
  localparam int VOTES  = 7;
  localparam int CNT_W  = 4;
  localparam int LAT    = 1 + VOTES * (2 * SETTLE + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [CH_W-1:0] req_ch = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic            rsp_bit;
  logic            rsp_stable;
  logic [CH_W-1:0] puf_ch;
  logic            puf_launch;
  logic            puf_arb_rst;
  logic            puf_resp = 1'b0;
  logic            busy;

  int total = 0;
  int bad   = 0;

  int   m_lat, m_clr_min, m_clr_max, m_lch_min, m_lch_max, m_lch_cnt, m_overlap, m_ch_bad;
  logic m_bit, m_stable;

  puf_challenge_sequencer #(
    .CH_W(CH_W), .SETTLE_CYC(SETTLE), .VOTES(VOTES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_ch(req_ch),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bit(rsp_bit), .rsp_stable(rsp_stable),
    .puf_ch(puf_ch), .puf_launch(puf_launch), .puf_arb_rst(puf_arb_rst), .puf_resp(puf_resp),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ones_of(input logic [14:0] p);
    int n = 0;
    for (int i = 0; i < VOTES; i++) n += int'(p[i]);
    return n;
  endfunction

  task automatic request(input logic [CH_W-1:0] ch, output bit ok);
    int n = 0;
    while (!req_ready && n < 500) begin step(); n++; end
    req_valid = 1'b1;
    req_ch    = ch;
    step();
    req_valid = 1'b0;
    ok = busy;
  endtask

  // Observes one evaluation starting the cycle after the accept edge, playing p[v] as the settled race result of vote v.
  task automatic monitor_job(input logic [CH_W-1:0] ch, input logic [14:0] p);
    int   cyc = 0, run = 0, lrun = 0, vi = 0;
    logic prev_l = 1'b0;
    m_lat = -1; m_clr_min = 9999; m_clr_max = 0; m_lch_min = 9999; m_lch_max = 0;
    m_lch_cnt = 0; m_overlap = 0; m_ch_bad = 0;
    puf_resp = 1'($urandom);
    while (cyc < LAT + 100) begin
      if (rsp_valid) begin m_lat = cyc; break; end
      if (puf_launch && puf_arb_rst) m_overlap++;
      if (puf_ch !== ch) m_ch_bad++;
      if (puf_launch && !prev_l) begin
        if (run < m_clr_min) m_clr_min = run;
        if (run > m_clr_max) m_clr_max = run;
        run = 0; lrun = 0; m_lch_cnt++;
        puf_resp = (vi < 15) ? p[vi] : 1'b0;
        vi++;
      end
      if (!puf_launch && prev_l) begin
        if (lrun < m_lch_min) m_lch_min = lrun;
        if (lrun > m_lch_max) m_lch_max = lrun;
        run = 0;
        puf_resp = 1'($urandom);
      end
      if (puf_launch) lrun++; else run++;
      prev_l = puf_launch;
      step();
      cyc++;
    end
    m_bit = rsp_bit;
    m_stable = rsp_stable;
  endtask

  task automatic finish_job();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    int seen = 0, n = 0;
    rst = 1'b0;
    repeat (3) step();
    total++;
    if ({req_ready, puf_arb_rst, puf_launch, rsp_valid, busy, rsp_bit, rsp_stable} !== 7'b1100000) begin
      bad++;
      $display("FAIL reset_state got=%b want=1100000",
               {req_ready, puf_arb_rst, puf_launch, rsp_valid, busy, rsp_bit, rsp_stable});
    end
    total++;
    if (puf_ch !== 8'h00) begin bad++; $display("FAIL reset_puf_ch got=%h want=00", puf_ch); end
    @(negedge clk); rst = 1'b1;
    step();
    request(8'h5A, ok);
    while (!puf_launch && n < 200) begin step(); n++; end
    repeat (5) step();
    total++;
    if (puf_launch !== 1'b1) begin bad++; $display("FAIL reset_reach_launch got=%b want=1", puf_launch); end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({req_ready, puf_arb_rst, puf_launch, rsp_valid, busy} !== 5'b11000) begin
      bad++;
      $display("FAIL reset_mid_launch got=%b want=11000", {req_ready, puf_arb_rst, puf_launch, rsp_valid, busy});
    end
    total++;
    if (puf_ch !== 8'h00) begin bad++; $display("FAIL reset_mid_puf_ch got=%h want=00", puf_ch); end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < LAT + 20; i++) begin step(); if (rsp_valid || busy) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL reset_no_partial got=%0d want=0", seen); end
  endtask

  task automatic test_all_ones();
    bit ok;
    request(8'hA5, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL ones_accept got=%b want=1", ok); end
    monitor_job(8'hA5, 15'h7fff);
    total++;
    if (m_lat !== LAT) begin bad++; $display("FAIL ones_latency got=%0d want=%0d", m_lat, LAT); end
    total++;
    if (m_ch_bad !== 0 || puf_ch !== 8'hA5) begin
      bad++; $display("FAIL ones_puf_ch got=%h bad_cycles=%0d want=a5", puf_ch, m_ch_bad);
    end
    total++;
    if ({m_bit, m_stable} !== 2'b11) begin bad++; $display("FAIL ones_result got=%b want=11", {m_bit, m_stable}); end
    finish_job();
    total++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      bad++; $display("FAIL ones_handshake got=%b want=01", {rsp_valid, req_ready});
    end
  endtask

  task automatic test_pattern();
    bit ok;
    request(8'h96, ok);
    monitor_job(8'h96, 15'b1001101);
    total++;
    if ({m_bit, m_stable} !== 2'b10) begin bad++; $display("FAIL pattern_1011001 got=%b want=10", {m_bit, m_stable}); end
    finish_job();
    request(8'h69, ok);
    monitor_job(8'h69, 15'b0110010);
    total++;
    if ({m_bit, m_stable} !== 2'b00) begin bad++; $display("FAIL pattern_inverted got=%b want=00", {m_bit, m_stable}); end
    finish_job();
  endtask

  task automatic test_hold();
    bit ok;
    int viol = 0;
    logic b0, s0;
    logic [14:0] p;
    p = 15'($urandom);
    request(8'hC3, ok);
    monitor_job(8'hC3, p);
    b0 = rsp_bit; s0 = rsp_stable;
    total++;
    if ({b0, s0} !== {1'(ones_of(p) > VOTES / 2), 1'(ones_of(p) == 0 || ones_of(p) == VOTES)}) begin
      bad++; $display("FAIL hold_result got=%b pattern=%b", {b0, s0}, p[VOTES-1:0]);
    end
    for (int i = 0; i < 50; i++) begin
      req_valid = 1'b1;
      req_ch    = 8'($urandom);
      step();
      if (rsp_valid !== 1'b1 || rsp_bit !== b0 || rsp_stable !== s0 || req_ready !== 1'b0 || puf_ch !== 8'hC3)
        viol++;
    end
    req_valid = 1'b0;
    total++;
    if (viol !== 0) begin bad++; $display("FAIL hold_frozen got=%0d violations want=0", viol); end
    finish_job();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [14:0] p;
    int o;
    request(8'h11, ok);
    monitor_job(8'h11, 15'($urandom));
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_ch    = 8'h3C;
    step();
    rsp_ready = 1'b0;
    total++;
    if ({busy, req_ready, rsp_valid} !== 3'b010 || puf_ch !== 8'h11) begin
      bad++; $display("FAIL b2b_idle_gap got=%b ch=%h want=010 ch=11", {busy, req_ready, rsp_valid}, puf_ch);
    end
    step();
    req_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || puf_ch !== 8'h3C) begin
      bad++; $display("FAIL b2b_accept got=busy%b ch=%h want=busy1 ch=3c", busy, puf_ch);
    end
    p = 15'($urandom);
    o = ones_of(p);
    monitor_job(8'h3C, p);
    total++;
    if (m_lat !== LAT) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", m_lat, LAT); end
    total++;
    if (m_bit !== 1'(o > VOTES / 2)) begin bad++; $display("FAIL b2b_bit got=%b ones=%0d", m_bit, o); end
    finish_job();
  endtask

  task automatic test_phase_timing();
    bit ok;
    request(8'($urandom), ok);
    monitor_job(req_ch, 15'($urandom));
    total++;
    if (m_clr_min !== SETTLE || m_clr_max !== SETTLE) begin
      bad++; $display("FAIL phase_clear got=%0d..%0d want=%0d", m_clr_min, m_clr_max, SETTLE);
    end
    total++;
    if (m_lch_min !== SETTLE + 1 || m_lch_max !== SETTLE + 1) begin
      bad++; $display("FAIL phase_launch got=%0d..%0d want=%0d", m_lch_min, m_lch_max, SETTLE + 1);
    end
    total++;
    if (m_lch_cnt !== VOTES) begin bad++; $display("FAIL phase_votes got=%0d want=%0d", m_lch_cnt, VOTES); end
    total++;
    if (m_overlap !== 0) begin bad++; $display("FAIL phase_overlap got=%0d want=0", m_overlap); end
    finish_job();
  endtask

  task automatic test_random();
    bit ok;
    logic [CH_W-1:0] ch;
    logic [14:0] p;
    int o;
    for (int j = 0; j < 8; j++) begin
      ch = 8'($urandom);
      p  = 15'($urandom);
      if (j == 0) p = 15'h0;
      o  = ones_of(p);
      request(ch, ok);
      monitor_job(ch, p);
      total++;
      if (m_lat !== LAT || m_ch_bad !== 0) begin
        bad++; $display("FAIL rand_timing job=%0d lat=%0d ch_bad=%0d want lat=%0d", j, m_lat, m_ch_bad, LAT);
      end
      total++;
      if ({m_bit, m_stable} !== {1'(o > VOTES / 2), 1'(o == 0 || o == VOTES)}) begin
        bad++; $display("FAIL rand_result job=%0d got=%b ones=%0d", j, {m_bit, m_stable}, o);
      end
      repeat ($urandom_range(0, 5)) step();
      finish_job();
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_pattern();
    test_hold();
    test_back_to_back();
    test_phase_timing();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
